// File: rtl/fft_unscramble.sv
// Bit-reverse reorder buffer: ping-pong RAM, writes at bitrev(iaddr), frames stream out in natural order.
// Latency: first oen 2 cycles after the edge accepting a frame's final write; then 1 sample/cycle.
// Backpressure: ordy stalls output via skid register; iready drops while both banks hold full frames.
module fft_unscramble #(
   parameter int TOTAL_STAGE = 10,
   parameter int CPLX_WIDTH  = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   ien,
   input  logic [TOTAL_STAGE-1:0] iaddr,
   input  logic [CPLX_WIDTH-1:0]  idata,
   output logic                   iready,
   output logic                   oen,
   input  logic                   ordy,
   output logic [TOTAL_STAGE-1:0] oaddr,
   output logic [CPLX_WIDTH-1:0]  odata,
   output logic                   olast,
   output logic                   ovf
);

   localparam int N = 1 << TOTAL_STAGE;
   localparam logic [TOTAL_STAGE-1:0] LAST_IDX = {TOTAL_STAGE{1'b1}};

   // Two banks laid out as one array, bank select in the address MSB.
   logic [CPLX_WIDTH-1:0] mem [2*N];
   logic [CPLX_WIDTH-1:0] ram_rdat_q;

   logic                   wr_bank_q, wr_bank_d;
   logic                   rd_bank_q, rd_bank_d;
   logic [1:0]             bank_full_q, bank_full_d;
   logic [TOTAL_STAGE-1:0] wr_cnt_q, wr_cnt_d;
   logic [TOTAL_STAGE-1:0] rd_cnt_q, rd_cnt_d;
   logic                   rd_done_q, rd_done_d;
   logic                   ovf_q, ovf_d;
   // Stage 1: RAM read in flight (data arrives in ram_rdat_q).
   logic                   s1_vld_q, s1_vld_d;
   logic [TOTAL_STAGE-1:0] s1_addr_q, s1_addr_d;
   // Skid entry behind the output register.
   logic                   sk_vld_q, sk_vld_d;
   logic [TOTAL_STAGE-1:0] sk_addr_q, sk_addr_d;
   logic [CPLX_WIDTH-1:0]  sk_dat_q, sk_dat_d;
   // Output register.
   logic                   oen_q, oen_d;
   logic [TOTAL_STAGE-1:0] oaddr_q, oaddr_d;
   logic [CPLX_WIDTH-1:0]  odata_q, odata_d;
   logic                   olast_q, olast_d;

   logic [TOTAL_STAGE-1:0] wr_idx;
   logic                   iready_c, wr_acc, pop, has_room, issue;
   logic [1:0]             occ;

   // Bit-reverse the incoming index to get the natural-order slot.
   always_comb begin
      wr_idx = '0;
      for (int i = 0; i < TOTAL_STAGE; i++) begin
         wr_idx[TOTAL_STAGE-1-i] = iaddr[i];
      end
   end

   // Handshake terms; a read is issued only if output reg + skid can absorb it next cycle.
   always_comb begin
      iready_c = !bank_full_q[wr_bank_q];
      wr_acc   = ien && iready_c;
      pop      = oen_q && ordy;
      occ      = {1'b0, oen_q} + {1'b0, sk_vld_q} + {1'b0, s1_vld_q};
      has_room = pop ? (occ <= 2'd2) : (occ <= 2'd1);
      issue    = bank_full_q[rd_bank_q] && !rd_done_q && has_room;
   end

   // Bank bookkeeping: write count, read issue count, full flags, overflow.
   always_comb begin
      wr_bank_d   = wr_bank_q;
      rd_bank_d   = rd_bank_q;
      bank_full_d = bank_full_q;
      wr_cnt_d    = wr_cnt_q;
      rd_cnt_d    = rd_cnt_q;
      rd_done_d   = rd_done_q;
      ovf_d       = ovf_q || (ien && !iready_c);
      if (wr_acc) begin
         if (wr_cnt_q == LAST_IDX) begin
            bank_full_d[wr_bank_q] = 1'b1;
            wr_bank_d              = !wr_bank_q;
            wr_cnt_d               = '0;
         end else begin
            wr_cnt_d = wr_cnt_q + 1'b1;
         end
      end
      if (issue) begin
         rd_cnt_d = rd_cnt_q + 1'b1;
         if (rd_cnt_q == LAST_IDX) begin
            rd_done_d = 1'b1;
         end
      end
      // The bank being written is never full, so this clear never targets the bank set above.
      if (pop && olast_q) begin
         bank_full_d[rd_bank_q] = 1'b0;
         rd_bank_d              = !rd_bank_q;
         rd_cnt_d               = '0;
         rd_done_d              = 1'b0;
      end
   end

   // Output pipeline: RAM data feeds the output register directly or parks in the skid entry.
   always_comb begin
      s1_vld_d  = issue;
      s1_addr_d = issue ? rd_cnt_q : s1_addr_q;
      sk_vld_d  = sk_vld_q;
      sk_addr_d = sk_addr_q;
      sk_dat_d  = sk_dat_q;
      oen_d     = oen_q;
      oaddr_d   = oaddr_q;
      odata_d   = odata_q;
      olast_d   = olast_q;
      if (!oen_q || pop) begin
         if (sk_vld_q) begin
            oen_d     = 1'b1;
            oaddr_d   = sk_addr_q;
            odata_d   = sk_dat_q;
            olast_d   = (sk_addr_q == LAST_IDX);
            sk_vld_d  = s1_vld_q;
            sk_addr_d = s1_addr_q;
            sk_dat_d  = ram_rdat_q;
         end else if (s1_vld_q) begin
            oen_d   = 1'b1;
            oaddr_d = s1_addr_q;
            odata_d = ram_rdat_q;
            olast_d = (s1_addr_q == LAST_IDX);
         end else begin
            oen_d   = 1'b0;
            olast_d = 1'b0;
         end
      end else if (s1_vld_q) begin
         sk_vld_d  = 1'b1;
         sk_addr_d = s1_addr_q;
         sk_dat_d  = ram_rdat_q;
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_bank_q   <= 1'b0;
         rd_bank_q   <= 1'b0;
         bank_full_q <= 2'b00;
         wr_cnt_q    <= '0;
         rd_cnt_q    <= '0;
         rd_done_q   <= 1'b0;
         ovf_q       <= 1'b0;
         s1_vld_q    <= 1'b0;
         s1_addr_q   <= '0;
         sk_vld_q    <= 1'b0;
         sk_addr_q   <= '0;
         sk_dat_q    <= '0;
         oen_q       <= 1'b0;
         oaddr_q     <= '0;
         odata_q     <= '0;
         olast_q     <= 1'b0;
      end else begin
         wr_bank_q   <= wr_bank_d;
         rd_bank_q   <= rd_bank_d;
         bank_full_q <= bank_full_d;
         wr_cnt_q    <= wr_cnt_d;
         rd_cnt_q    <= rd_cnt_d;
         rd_done_q   <= rd_done_d;
         ovf_q       <= ovf_d;
         s1_vld_q    <= s1_vld_d;
         s1_addr_q   <= s1_addr_d;
         sk_vld_q    <= sk_vld_d;
         sk_addr_q   <= sk_addr_d;
         sk_dat_q    <= sk_dat_d;
         oen_q       <= oen_d;
         oaddr_q     <= oaddr_d;
         odata_q     <= odata_d;
         olast_q     <= olast_d;
      end
   end

   // Ping-pong RAM: one write port, one registered read port, contents not reset.
   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem[{wr_bank_q, wr_idx}] <= idata;
      end
      if (issue) begin
         ram_rdat_q <= mem[{rd_bank_q, rd_cnt_q}];
      end
   end

   assign iready = iready_c;
   assign oen    = oen_q;
   assign oaddr  = oaddr_q;
   assign odata  = odata_q;
   assign olast  = olast_q;
   assign ovf    = ovf_q;

endmodule

// File: tb/tb_fft_unscramble.sv
// Bench for fft_unscramble at TOTAL_STAGE=3: scoreboard of expected natural-order output.
// Expected frames are built from accepted writes and popped on each oen&&ordy transfer.
// Output is sampled on the falling edge; inputs change 1 time unit after the rising edge.
module tb_fft_unscramble;
   localparam int TS = 3;
   localparam int W  = 32;
   localparam int N  = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          ien = 1'b0;
   logic [TS-1:0] iaddr = '0;
   logic [W-1:0]  idata = '0;
   logic          iready;
   logic          oen;
   logic          ordy = 1'b0;
   logic [TS-1:0] oaddr;
   logic [W-1:0]  odata;
   logic          olast;
   logic          ovf;

   fft_unscramble #(.TOTAL_STAGE(TS), .CPLX_WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .ien(ien), .iaddr(iaddr), .idata(idata),
      .iready(iready), .oen(oen), .ordy(ordy), .oaddr(oaddr), .odata(odata),
      .olast(olast), .ovf(ovf)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [TS-1:0] a;
      logic [W-1:0]  d;
      logic          l;
      logic          known;
   } exp_t;

   exp_t        exp_q[$];
   logic [W-1:0] fm[N];
   bit          fm_known[N];
   int          fcnt = 0;
   int          n_chk = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          last_wr_cyc = -1;
   int          first_oen_cyc = -1;
   int          last_xfer_cyc = -1;
   int          rdy_mode = 0;
   bit          gap_chk = 0;
   bit          rdy_after_last = 0;
   bit          rdy_pend = 0;
   bit          hold_prev = 0;
   bit          oen_prev = 0;
   logic [36:0] hold_val;

   always @(posedge clk) cyc = cyc + 1;

   task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic logic [TS-1:0] brev(input logic [TS-1:0] a);
      return {a[0], a[1], a[2]};
   endfunction

   // Output monitor / scoreboard consumer.
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         hold_prev = 0;
         oen_prev  = 0;
         rdy_pend  = 0;
      end else begin
         if (rdy_pend) begin
            chk_eq("iready_after_olast", iready, 1);
            rdy_pend       = 0;
            rdy_after_last = 0;
         end
         if (hold_prev) chk_eq("hold_stable", {oen, olast, oaddr, odata}, hold_val);
         if (oen && !oen_prev) first_oen_cyc = cyc;
         if (oen && ordy) begin
            chk_eq("sb_has_entry", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               chk_eq("oaddr", oaddr, e.a);
               if (e.known) chk_eq("odata", odata, e.d);
               chk_eq("olast", olast, e.l);
            end
            if (gap_chk && oaddr == 0 && last_xfer_cyc >= 0)
               chk_eq("frame_gap_le2", (cyc - last_xfer_cyc) <= 3, 1);
            if (olast) begin
               last_xfer_cyc = cyc;
               if (rdy_after_last) begin
                  chk_eq("iready_before_free", iready, 0);
                  rdy_pend = 1;
               end
            end
         end
         hold_prev = oen && !ordy;
         hold_val  = {oen, olast, oaddr, odata};
         oen_prev  = oen;
      end
   end

   // Random ready generator, active only in mode 2.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rdy_mode == 2) ordy = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drive one sample; acc says whether the bench expects it to be taken.
   task automatic send(input logic [TS-1:0] a, input logic [W-1:0] d, input bit wait_rdy, input bit acc);
      exp_t e;
      int   t;
      t = 0;
      if (wait_rdy) begin
         while (!iready && t < 300) begin
            @(posedge clk);
            #1;
            t++;
         end
         chk_eq("iready_wait", iready, 1);
      end
      ien   = 1'b1;
      iaddr = a;
      idata = d;
      @(posedge clk);
      #1;
      ien = 1'b0;
      if (acc) begin
         fm[brev(a)]       = d;
         fm_known[brev(a)] = 1;
         fcnt++;
         if (fcnt == N) begin
            fcnt        = 0;
            last_wr_cyc = cyc;
            for (int k = 0; k < N; k++) begin
               e.a   = k[TS-1:0];
               e.d   = fm[k];
               e.l   = (k == N - 1);
               e.known = fm_known[k];
               fm_known[k] = 0;
               exp_q.push_back(e);
            end
         end
      end
   endtask

   task automatic drain(input int budget);
      int t;
      t = 0;
      while ((exp_q.size() != 0 || oen) && t < budget) begin
         @(posedge clk);
         #1;
         t++;
      end
      chk_eq("drain_empty", exp_q.size(), 0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      ien   = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      exp_q.delete();
      fcnt = 0;
      for (int k = 0; k < N; k++) fm_known[k] = 0;
      last_xfer_cyc = -1;
      chk_eq("rst_oen", oen, 0);
      chk_eq("rst_iready", iready, 1);
      chk_eq("rst_ovf", ovf, 0);
   endtask

   initial begin
      logic [TS-1:0] dup_a[8];
      logic [W-1:0]  dup_d[8];
      dup_a = '{3'd0, 3'd1, 3'd3, 3'd4, 3'd5, 3'd5, 3'd6, 3'd7};
      dup_d = '{32'h600, 32'h601, 32'h603, 32'h604, 32'hAA, 32'hBB, 32'h606, 32'h607};

      // Power-on reset values.
      repeat (2) @(posedge clk);
      #1;
      chk_eq("init_oen", oen, 0);
      chk_eq("init_olast", olast, 0);
      chk_eq("init_oaddr", oaddr, 0);
      chk_eq("init_odata", odata, 0);
      chk_eq("init_ovf", ovf, 0);
      chk_eq("init_iready", iready, 1);
      rst_n = 1'b1;
      idle(1);

      // Basic frame with ordy high; check first-output latency.
      ordy = 1'b1;
      for (int a = 0; a < N; a++) send(a[TS-1:0], 32'h100 + a, 0, 1);
      drain(100);
      chk_eq("first_oen_latency", first_oen_cyc - last_wr_cyc, 2);

      // Overflow: two frames stored with ordy low, third frame dropped.
      do_reset();
      ordy = 1'b0;
      for (int f = 0; f < 2; f++)
         for (int a = 0; a < N; a++) send(a[TS-1:0], 32'h200 + 16 * f + a, 0, 1);
      chk_eq("iready_both_full", iready, 0);
      for (int a = 0; a < N; a++) begin
         chk_eq("iready_ovf_frame", iready, 0);
         send(a[TS-1:0], 32'hDEAD0000 + a, 0, 0);
      end
      chk_eq("ovf_set", ovf, 1);
      idle(3);
      rdy_after_last = 1;
      ordy = 1'b1;
      drain(200);
      chk_eq("ovf_sticky", ovf, 1);
      chk_eq("iready_return_seen", rdy_after_last, 0);

      // Random ordy over four frames.
      do_reset();
      rdy_mode = 2;
      for (int f = 0; f < 4; f++)
         for (int a = 0; a < N; a++) send(a[TS-1:0], $urandom, 1, 1);
      drain(600);
      rdy_mode = 0;
      ordy = 1'b1;

      // Continuous frames with ordy high; inter-frame output gap bounded.
      do_reset();
      gap_chk = 1;
      for (int f = 0; f < 6; f++) begin
         for (int a = 0; a < N; a++) begin
            chk_eq("iready_continuous", iready, 1);
            send(a[TS-1:0], $urandom, 0, 1);
         end
         idle(2);
      end
      drain(200);
      chk_eq("ovf_continuous", ovf, 0);
      gap_chk = 0;

      // Reset while reading frame 1 and writing frame 2, then a fresh frame.
      do_reset();
      for (int a = 0; a < N; a++) send(a[TS-1:0], 32'h500 + a, 0, 1);
      for (int a = 0; a < 4; a++) send(a[TS-1:0], 32'h510 + a, 0, 1);
      chk_eq("oen_before_rst", oen, 1);
      do_reset();
      for (int a = 0; a < N; a++) send(a[TS-1:0], 32'h700 + 3 * a, 0, 1);
      drain(100);

      // Duplicate index 5, index 2 never written.
      do_reset();
      for (int i = 0; i < N; i++) send(dup_a[i], dup_d[i], 0, 1);
      drain(100);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/fft_unscramble.md
Name: fft_unscramble

Overview:
- Bit-reverse reorder buffer for the FFT output side.
- Accepts a frame of 2^TOTAL_STAGE complex samples tagged with a bit-reversed index (ien/iaddr/idata stream from the butterfly pipeline).
- Stores each sample at the bit-reversed location of its index in a ping-pong RAM.
- Streams each completed frame out in natural order with a valid/ready handshake and frame-last marker.

Parameters:
- TOTAL_STAGE, 10, log2 of FFT length N; frame size = 2^TOTAL_STAGE samples.
- CPLX_WIDTH, 32, width of one complex sample ({re, im} packed, opaque to this block).

Ports:
- clk  input  1  single clock, all logic on rising edge
- rst_n  input  1  synchronous, active-low reset
- ien  input  1  input sample valid
- iaddr  input  TOTAL_STAGE  bit-reversed sample index
- idata  input  CPLX_WIDTH  input sample
- iready  output  1  write bank available; sample accepted on ien&&iready
- oen  output  1  output sample valid
- ordy  input  1  downstream ready; transfer on oen&&ordy
- oaddr  output  TOTAL_STAGE  natural-order index of odata
- odata  output  CPLX_WIDTH  output sample
- olast  output  1  high with the sample at oaddr = N-1
- ovf  output  1  sticky: sample offered while iready low

Behaviour:
- Reset (rst_n low at clk edge): oen=0, olast=0, oaddr=0, odata=0, ovf=0, iready=1. wr_bank=0, rd_bank=0, wr_cnt=0, rd_cnt=0, both bank_full flags=0. RAM contents are not reset. Reset mid-frame discards all partial and full frames.
- Storage: two banks of N x CPLX_WIDTH, inferred synchronous RAM with 1-cycle read latency.
- Write side:
  - On ien&&iready: mem[wr_bank][bitrev(iaddr)] <= idata, where bitrev maps iaddr[i] to position TOTAL_STAGE-1-i; wr_cnt increments.
  - On the accepted write with wr_cnt==N-1: bank_full[wr_bank]<=1, wr_bank toggles, wr_cnt<=0.
  - Frame completion is by write count, not address coverage. Duplicate iaddr within a frame: last write wins.
- iready = !bank_full[wr_bank], taken from registered state; no combinational path from ordy.
- ien while !iready: sample dropped, counters unchanged, ovf<=1 until reset.
- Read side:
  - When bank_full[rd_bank]=1, read addresses rd_cnt = 0..N-1 of rd_bank in order.
  - oaddr = index of the presented sample; olast = (oaddr==N-1).
  - First oen for a frame rises exactly 2 cycles after the clock edge that accepted that frame's final write, provided rd_bank is idle.
- Handshake:
  - While oen&&!ordy: oen, oaddr, odata and olast hold stable.
  - With ordy held high: one sample per cycle, no bubbles within a frame. Implement with prefetch/skid register.
  - Back-to-back full frames: at most 2 idle cycles between olast and the next frame's oaddr=0.
- On the transfer with olast=1: bank_full[rd_bank]<=0, rd_bank toggles, rd_cnt<=0. The freed bank's iready rises the following cycle.
- Simultaneous events:
  - Final write of one bank and final read of the other in the same cycle: both flag updates apply independently.
  - Write into wr_bank and read from rd_bank are never the same bank while that bank is full, so no read/write collision.
- Both banks full: iready=0; the input stalls or overflows per the rules above.

Test Plan:
- TOTAL_STAGE=3. Reset, then write 8 samples with iaddr=0..7 and idata=0x100+iaddr, ordy=1 -> oaddr 0..7 in order with odata=0x100+bitrev(oaddr), i.e. 0x100,0x104,0x102,0x106,0x101,0x105,0x103,0x107. olast only at oaddr=7. First oen exactly 2 cycles after the 8th write.
- Three frames written back-to-back with ordy=0 -> iready falls after frame 2 completes. Frame 3 samples while iready=0 are dropped and ovf=1. Then raise ordy -> frames 1 and 2 drain intact in order, and iready returns 1 cycle after the frame-1 olast transfer.
- Random ordy toggling (50%) over 4 frames -> no lost or duplicated samples. odata/oaddr/olast stable during every oen&&!ordy cycle.
- Continuous input and ordy=1 for 6 frames -> iready never falls, ovf stays 0, gap between frames is 2 idle cycles or fewer.
- Assert rst_n=0 for 1 cycle mid-way through the read of frame 1 and the write of frame 2 -> next cycle oen=0, iready=1, ovf=0. A fresh frame written afterwards outputs correctly.
- Frame with iaddr=5 written twice (0xAA then 0xBB) and iaddr=2 never written, 8 writes total -> frame completes. oaddr=bitrev(5)=5 gives 0xBB. oaddr=bitrev(2)=2 gives the stale RAM content; the bench checks only that the sample is present.
